// File: rtl/reg_dump_reader.sv
// Debug reader: walks a range of register-file entries and streams them as a
// header/address/data/checksum byte frame over a valid/ready byte interface.
module reg_dump_reader #(
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31,
  parameter logic [7:0]  HDR_BYTE  = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam logic [4:0] FirstIdx = 5'(FIRST_REG);
  localparam logic [4:0] LastIdx  = 5'(LAST_REG);

  typedef enum logic [3:0] {
    StIdle, StHdr, StLoad, StAddr, StB3, StB2, StB1, StB0, StCsum, StDone
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  idx_q;
  logic [31:0] shadow_q;
  logic [7:0]  csum_q;
  logic        tx_fire;
  logic        in_body;

  assign tx_fire = tx_valid && tx_ready;
  assign in_body = (state_q == StAddr) || (state_q == StB3) || (state_q == StB2) ||
                   (state_q == StB1) || (state_q == StB0);
  assign rd_addr = idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StHdr;
      StHdr:  if (tx_ready) state_d = StLoad;
      StLoad: state_d = StAddr;
      StAddr: if (tx_ready) state_d = StB3;
      StB3:   if (tx_ready) state_d = StB2;
      StB2:   if (tx_ready) state_d = StB1;
      StB1:   if (tx_ready) state_d = StB0;
      StB0:   if (tx_ready) state_d = (idx_q == LastIdx) ? StCsum : StLoad;
      StCsum: if (tx_ready) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q    <= FirstIdx;
      shadow_q <= '0;
      csum_q   <= '0;
    end else begin
      if (state_q == StIdle && start) begin
        idx_q  <= FirstIdx;
        csum_q <= '0;
      end
      // Snapshot once per register so later rd_data changes cannot leak into the frame.
      if (state_q == StLoad) begin
        shadow_q <= rd_data;
      end
      if (tx_fire && in_body) begin
        csum_q <= csum_q ^ tx_data;
      end
      if (state_q == StB0 && tx_ready && idx_q != LastIdx) begin
        idx_q <= idx_q + 5'd1;
      end
    end
  end

  // Outputs decode only state and registers; tx_ready never reaches them.
  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    busy     = (state_q != StIdle);
    done     = (state_q == StDone);
    unique case (state_q)
      StHdr:  begin tx_valid = 1'b1; tx_data = HDR_BYTE;        end
      StAddr: begin tx_valid = 1'b1; tx_data = {3'b000, idx_q}; end
      StB3:   begin tx_valid = 1'b1; tx_data = shadow_q[31:24]; end
      StB2:   begin tx_valid = 1'b1; tx_data = shadow_q[23:16]; end
      StB1:   begin tx_valid = 1'b1; tx_data = shadow_q[15:8];  end
      StB0:   begin tx_valid = 1'b1; tx_data = shadow_q[7:0];   end
      StCsum: begin tx_valid = 1'b1; tx_data = csum_q;          end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Bench for reg_dump_reader: a full-range instance and a single-register
// instance share a register-file model; frames are captured and checked.
module tb_reg_dump_reader;

  localparam int unsigned FullFirst = 0;
  localparam int unsigned FullLast  = 31;
  localparam int unsigned OneFirst  = 9;
  localparam int unsigned OneLast   = 9;

  initial begin
    assert (FullLast >= FullFirst && OneLast >= OneFirst)
      else $fatal(1, "FAIL param_range: LAST_REG below FIRST_REG");
  end

  logic        clk = 1'b0;
  logic        rst, start, start1;
  logic        busy, done, busy1, done1;
  logic [4:0]  rd_addr, rd_addr1;
  logic [31:0] rd_data, rd_data1;
  logic [7:0]  tx_data, tx_data1;
  logic        tx_valid, tx_valid1;
  logic        tx_ready = 1'b1;
  logic        rand_ready = 1'b0;
  logic [31:0] regs [32];

  always #5 clk = ~clk;

  assign rd_data  = regs[rd_addr];
  assign rd_data1 = regs[rd_addr1];

  reg_dump_reader #(.FIRST_REG(FullFirst), .LAST_REG(FullLast), .HDR_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_data(rd_data), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready)
  );

  reg_dump_reader #(.FIRST_REG(OneFirst), .LAST_REG(OneLast), .HDR_BYTE(8'hA5)) dut_one (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .rd_addr(rd_addr1), .rd_data(rd_data1), .tx_data(tx_data1), .tx_valid(tx_valid1),
    .tx_ready(1'b1)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Monitor: transfers, done pulses and hold-under-backpressure, sampled mid-cycle.
  logic [7:0] cap[$];
  logic [7:0] cap1[$];
  int         done_cnt = 0;
  int         done_cnt1 = 0;
  int         proto_err = 0;
  logic       pv = 1'b0, pr = 1'b0, prst = 1'b1;
  logic [7:0] pd = 8'h00;

  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) cap.push_back(tx_data);
    if (!rst && tx_valid1) cap1.push_back(tx_data1);
    if (!rst && done) done_cnt <= done_cnt + 1;
    if (!rst && done1) done_cnt1 <= done_cnt1 + 1;
    if (pv && !pr && !prst && (!tx_valid || tx_data !== pd)) proto_err <= proto_err + 1;
    pv   <= tx_valid;
    pr   <= tx_ready;
    pd   <= tx_data;
    prst <= rst;
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) tx_ready = ($urandom_range(0, 1) == 1);
  end

  logic [7:0] exp_q[$];

  task automatic build_exp(input int f, input int l);
    logic [7:0] cs;
    cs = 8'h00;
    exp_q = {};
    exp_q.push_back(8'hA5);
    for (int i = f; i <= l; i++) begin
      logic [31:0] d;
      d = regs[i];
      exp_q.push_back(8'(i));
      exp_q.push_back(d[31:24]);
      exp_q.push_back(d[23:16]);
      exp_q.push_back(d[15:8]);
      exp_q.push_back(d[7:0]);
      cs = cs ^ 8'(i) ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
    end
    exp_q.push_back(cs);
  endtask

  task automatic cmp_frame(input string name, input logic [7:0] got[$],
                           input logic [7:0] exp[$]);
    int bad;
    bad = -1;
    chk({name, " len"}, got.size(), exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      if (got[i] !== exp[i] && bad < 0) bad = i;
    chk({name, " first_bad_idx"}, bad, -1);
  endtask

  // Start the full instance, hold start for `hold` cycles, optionally re-pulse
  // start once `pulse_at` bytes have gone out, and wait for done.
  task automatic run(input int hold, input int pulse_at, output int cyc, output bit found);
    bit pulsed, pulse_on;
    pulsed = 0; pulse_on = 0; found = 0; cyc = 0;
    start = 1'b1;
    while (!found && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == hold) start = 1'b0;
      if (pulse_on) begin start = 1'b0; pulse_on = 0; end
      if (pulse_at > 0 && !pulsed && cap.size() >= pulse_at) begin
        start = 1'b1; pulsed = 1; pulse_on = 1;
      end
      if (done) found = 1;
    end
    start = 1'b0;
  endtask

  typedef struct {
    string      name;
    int         pos;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[9];
  vec_t tbl1[7];

  initial begin
    int  cyc, busy_hits, dsnap;
    bit  found, arm, changed;

    tbl[0] = '{"hdr", 0, 8'hA5};      tbl[1] = '{"addr0", 1, 8'h00};
    tbl[2] = '{"addr9", 46, 8'h09};   tbl[3] = '{"r9_b3", 47, 8'h00};
    tbl[4] = '{"r9_b0", 50, 8'h18};   tbl[5] = '{"addr11", 56, 8'h0B};
    tbl[6] = '{"r11_b0", 60, 8'h08};  tbl[7] = '{"addr31", 156, 8'h1F};
    tbl[8] = '{"csum", 161, 8'h10};
    tbl1[0] = '{"one_hdr", 0, 8'hA5}; tbl1[1] = '{"one_addr", 1, 8'h09};
    tbl1[2] = '{"one_b3", 2, 8'h00};  tbl1[3] = '{"one_b2", 3, 8'h00};
    tbl1[4] = '{"one_b1", 4, 8'h00};  tbl1[5] = '{"one_b0", 5, 8'h18};
    tbl1[6] = '{"one_csum", 6, 8'h11};

    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    regs[9]  = 32'h0000_0018;
    regs[11] = 32'h0000_0008;

    rst = 1'b1; start = 1'b0; start1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", busy, 0);       chk("rst done", done, 0);
    chk("rst tx_valid", tx_valid, 0); chk("rst tx_data", tx_data, 0);
    chk("rst rd_addr", rd_addr, 0); chk("rst rd_addr_one", rd_addr1, 9);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single-register instance, including a start that lands in the DONE cycle.
    cap1 = {};
    dsnap = done_cnt1;
    start1 = 1'b1;
    found = 0; cyc = 0;
    while (!found && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      start1 = 1'b0;
      if (done1) found = 1;
    end
    chk("one done seen", found, 1);
    chk("one busy in done", busy1, 1);
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    chk("one busy after done", busy1, 0);
    chk("one valid after done", tx_valid1, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("one start in done ignored", busy1, 0);
    chk("one done pulses", done_cnt1 - dsnap, 1);
    chk("one len", cap1.size(), 7);
    for (int i = 0; i < 7; i++)
      chk(tbl1[i].name, (tbl1[i].pos < cap1.size()) ? cap1[tbl1[i].pos] : 8'hxx, tbl1[i].exp);

    // Full default dump with tx_ready held high.
    build_exp(FullFirst, FullLast);
    cap = {};
    dsnap = done_cnt;
    run(1, 0, cyc, found);
    chk("full done seen", found, 1);
    chk("full cycles to done", cyc, 195);
    chk("full len", cap.size(), 162);
    for (int i = 0; i < 9; i++)
      chk(tbl[i].name, (tbl[i].pos < cap.size()) ? cap[tbl[i].pos] : 8'hxx, tbl[i].exp);
    cmp_frame("full model", cap, exp_q);
    busy_hits = 0;
    for (int k = 0; k < 32; k++)
      if (1 + 5 * k < cap.size() && cap[1 + 5 * k] !== 8'(k)) busy_hits++;
    chk("addr order errors", busy_hits, 0);
    @(posedge clk); #1;
    chk("full busy after done", busy, 0);
    chk("full done pulses", done_cnt - dsnap, 1);

    // Random backpressure: same stream, data and valid held while stalled.
    cap = {};
    proto_err = 0;
    rand_ready = 1'b1;
    run(1, 0, cyc, found);
    rand_ready = 1'b0;
    tx_ready = 1'b1;
    chk("bp done seen", found, 1);
    cmp_frame("bp frame", cap, exp_q);
    chk("bp hold violations", proto_err, 0);
    @(posedge clk); #1;

    // Snapshot: reg9 changes right after its LOAD cycle.
    cap = {};
    start = 1'b1;
    found = 0; cyc = 0; arm = 0; changed = 0;
    while (!found && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      if (arm) begin regs[9] = 32'hDEAD_BEEF; arm = 0; changed = 1; end
      if (!changed && busy && !tx_valid && rd_addr == 5'd9) arm = 1;
      if (done) found = 1;
    end
    chk("snap changed", changed, 1);
    cmp_frame("snap frame", cap, exp_q);
    chk("snap r9 word", (cap.size() > 50) ? {cap[47], cap[48], cap[49], cap[50]} : 32'hx,
        32'h0000_0018);
    regs[9] = 32'h0000_0018;
    @(posedge clk); #1;

    // Reset mid-frame after 20 bytes, then a clean dump.
    cap = {};
    dsnap = done_cnt;
    start = 1'b1;
    cyc = 0;
    while (cap.size() < 20 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
    end
    chk("rst reached 20 bytes", cap.size(), 20);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst tx_valid", tx_valid, 0);
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst rd_addr", rd_addr, 0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("midrst no done", done_cnt - dsnap, 0);
    cap = {};
    run(1, 0, cyc, found);
    chk("after rst done seen", found, 1);
    cmp_frame("after rst frame", cap, exp_q);
    @(posedge clk); #1;

    // Restart pulse mid-frame and a start held for three cycles: one frame each.
    for (int t = 0; t < 2; t++) begin
      cap = {};
      dsnap = done_cnt;
      if (t == 0) run(1, 50, cyc, found);
      else run(3, 0, cyc, found);
      chk(t == 0 ? "repulse done seen" : "hold3 done seen", found, 1);
      cmp_frame(t == 0 ? "repulse frame" : "hold3 frame", cap, exp_q);
      busy_hits = 0;
      repeat (12) begin
        @(posedge clk); #1;
        if (busy || tx_valid) busy_hits++;
      end
      chk(t == 0 ? "repulse no restart" : "hold3 no restart", busy_hits, 0);
      chk(t == 0 ? "repulse done pulses" : "hold3 done pulses", done_cnt - dsnap, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
